// File: rtl/nn_mem_pkg.sv
// Shared definitions for the binarized-NN memory responder: FSM/target encodings,
// default bank depths and the depth lookup used by preload and range checks.
package nn_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        TGT_W = 1'b0,
        TGT_X = 1'b1
    } target_e;

    // Wide enough to hold a depth of 2**20.
    localparam int DEPTH_W = 21;

    localparam int W_DEPTH0_DEF = 802816;
    localparam int W_DEPTH1_DEF = 1048576;
    localparam int W_DEPTH2_DEF = 1048576;
    localparam int W_DEPTH3_DEF = 10240;
    localparam int X_DEPTH_DEF  = 1024;

    function automatic logic [DEPTH_W-1:0] bank_depth(
        input target_e            tgt,
        input logic [1:0]         sel,
        input logic [DEPTH_W-1:0] wd0,
        input logic [DEPTH_W-1:0] wd1,
        input logic [DEPTH_W-1:0] wd2,
        input logic [DEPTH_W-1:0] wd3,
        input logic [DEPTH_W-1:0] xd
    );
        logic [DEPTH_W-1:0] d;
        if (tgt == TGT_X) begin
            d = xd;
        end else begin
            case (sel)
                2'd0:    d = wd0;
                2'd1:    d = wd1;
                2'd2:    d = wd2;
                default: d = wd3;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/nn_bit_bank.sv
// 1-bit RAM with one write port and a registered, read-first read port.
// Addresses beyond DEPTH read as 0 and never write.
module nn_bit_bank #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rdata
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < DEPTH_V)) begin
            mem[waddr] <= wdata;
        end
        if ({1'b0, raddr} < DEPTH_V) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= 1'b0;
        end
    end

endmodule

// File: rtl/nn_mem_responder.sv
// Memory-side responder for the binarized-NN engine: four weight and four activation
// 1-bit banks, engine read/write service, and a serial preload port.
module nn_mem_responder #(
    parameter int W_ADDR_LEN = 20,
    parameter int X_ADDR_LEN = 10,
    parameter int SEL_LEN    = 2,
    parameter int W_DEPTH0   = 802816,
    parameter int W_DEPTH1   = 1048576,
    parameter int W_DEPTH2   = 1048576,
    parameter int W_DEPTH3   = 10240,
    parameter int X_DEPTH    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_start,
    input  logic                  ld_target,
    input  logic [SEL_LEN-1:0]    ld_sel,
    input  logic                  ld_valid,
    input  logic                  ld_data,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  mem_ready,
    input  logic [W_ADDR_LEN-1:0] w_addr,
    input  logic [SEL_LEN-1:0]    w_sel,
    output logic                  w_data,
    input  logic [X_ADDR_LEN-1:0] x_addr,
    input  logic [SEL_LEN-1:0]    x_sel,
    input  logic                  x_wq,
    input  logic                  wx_write,
    output logic                  x_data,
    output logic                  err_oob
);

    import nn_mem_pkg::*;

    localparam logic [DEPTH_W-1:0] WD0 = DEPTH_W'(W_DEPTH0);
    localparam logic [DEPTH_W-1:0] WD1 = DEPTH_W'(W_DEPTH1);
    localparam logic [DEPTH_W-1:0] WD2 = DEPTH_W'(W_DEPTH2);
    localparam logic [DEPTH_W-1:0] WD3 = DEPTH_W'(W_DEPTH3);
    localparam logic [DEPTH_W-1:0] XD  = DEPTH_W'(X_DEPTH);

    state_e                 state;
    state_e                 state_next;
    logic                   live;
    target_e                ld_tgt;
    logic [SEL_LEN-1:0]     ld_bank;
    logic [W_ADDR_LEN-1:0]  ld_cnt;

    logic                   in_idle;
    logic                   in_load;
    logic [DEPTH_W-1:0]     ld_depth;
    logic [DEPTH_W-1:0]     w_depth;
    logic [DEPTH_W-1:0]     x_depth;
    logic                   w_in_range;
    logic                   x_in_range;
    logic                   ld_accept;
    logic                   ld_last;
    logic                   eng_we;
    logic                   err_set;

    logic                   w_ok_p1;
    logic                   x_ok_p1;
    logic [SEL_LEN-1:0]     w_sel_p1;
    logic [SEL_LEN-1:0]     x_sel_p1;
    logic [3:0]             w_rd;
    logic [3:0]             x_rd;

    assign in_idle    = (state == IDLE);
    assign in_load    = (state == LOAD);
    assign ld_depth   = bank_depth(ld_tgt, ld_bank, WD0, WD1, WD2, WD3, XD);
    assign w_depth    = bank_depth(TGT_W, w_sel, WD0, WD1, WD2, WD3, XD);
    assign x_depth    = bank_depth(TGT_X, x_sel, WD0, WD1, WD2, WD3, XD);
    assign w_in_range = (DEPTH_W'(w_addr) < w_depth);
    assign x_in_range = (DEPTH_W'(x_addr) < x_depth);

    // A reset edge abandons the load and any pending engine write.
    assign ld_accept  = rst && in_load && ld_valid;
    assign ld_last    = ld_accept && (DEPTH_W'(ld_cnt) == (ld_depth - DEPTH_W'(1)));
    assign eng_we     = rst && in_idle && x_wq && x_in_range;
    assign err_set    = (in_idle && (!w_in_range || !x_in_range)) || (x_wq && !in_idle);

    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        ld_done    = 1'b0;
        mem_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                mem_ready = live;
                if (ld_start) state_next = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_last) state_next = DONE;
            end
            DONE: begin
                ld_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            live    <= 1'b0;
            ld_tgt  <= TGT_W;
            ld_bank <= '0;
            ld_cnt  <= '0;
            err_oob <= 1'b0;
            w_ok_p1 <= 1'b0;
            x_ok_p1 <= 1'b0;
        end else begin
            state <= state_next;
            live  <= 1'b1;
            if (in_idle && ld_start) begin
                ld_tgt  <= target_e'(ld_target);
                ld_bank <= ld_sel;
                ld_cnt  <= '0;
            end else if (ld_accept && !ld_last) begin
                ld_cnt <= ld_cnt + W_ADDR_LEN'(1);
            end
            if (err_set) err_oob <= 1'b1;
            w_ok_p1 <= in_idle && w_in_range;
            x_ok_p1 <= in_idle && x_in_range;
        end
    end

    // ---- read stage p0 -> p1: bank select follows the registered read data
    always_ff @(posedge clk) begin
        w_sel_p1 <= w_sel;
        x_sel_p1 <= x_sel;
    end

    for (genvar b = 0; b < 4; b++) begin : g_banks
        localparam int WDEPTH_B = (b == 0) ? W_DEPTH0 :
                                  (b == 1) ? W_DEPTH1 :
                                  (b == 2) ? W_DEPTH2 : W_DEPTH3;

        logic w_we;
        logic x_we;

        assign w_we = ld_accept && (ld_tgt == TGT_W) && (ld_bank == SEL_LEN'(b));
        assign x_we = (ld_accept && (ld_tgt == TGT_X) && (ld_bank == SEL_LEN'(b))) ||
                      (eng_we && (x_sel == SEL_LEN'(b)));

        nn_bit_bank #(
            .DEPTH  (WDEPTH_B),
            .ADDR_W (W_ADDR_LEN)
        ) u_w_bank (
            .clk   (clk),
            .we    (w_we),
            .waddr (ld_cnt),
            .wdata (ld_data),
            .raddr (w_addr),
            .rdata (w_rd[b])
        );

        nn_bit_bank #(
            .DEPTH  (X_DEPTH),
            .ADDR_W (X_ADDR_LEN)
        ) u_x_bank (
            .clk   (clk),
            .we    (x_we),
            .waddr (in_load ? ld_cnt[X_ADDR_LEN-1:0] : x_addr),
            .wdata (in_load ? ld_data : wx_write),
            .raddr (x_addr),
            .rdata (x_rd[b])
        );
    end

    assign w_data = in_idle && w_ok_p1 && w_rd[w_sel_p1];
    assign x_data = in_idle && x_ok_p1 && x_rd[x_sel_p1];

endmodule
